// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-unit signal bundle: IF/ID and ID/EX fields in, stage enables
// and status out. The pipeline drives through "master"; the controller uses "slave".
interface hazard_controller_if;
  logic [4:0]  rs_FD;
  logic [4:0]  rt_FD;
  logic [4:0]  rt_DX;
  logic        memRead_DX;
  logic        branchTaken_DX;
  logic        mdStart_DX;
  logic        pcWrite;
  logic        writeFD;
  logic        writeDX;
  logic        flushFD;
  logic        bubbleDX;
  logic        mdDone;
  logic [1:0]  state;
  logic [15:0] stallCount;

  // Mult/div handshake: the pipeline holds mdStart_DX high to issue; the controller
  // freezes the pipe and pulses mdDone for exactly one cycle when the result is ready.
  // The pipeline must present mdStart_DX low after that pulse unless it issues anew.
  modport master (
    output rs_FD, rt_FD, rt_DX, memRead_DX, branchTaken_DX, mdStart_DX,
    input  pcWrite, writeFD, writeDX, flushFD, bubbleDX, mdDone, state, stallCount
  );

  modport slave (
    input  rs_FD, rt_FD, rt_DX, memRead_DX, branchTaken_DX, mdStart_DX,
    output pcWrite, writeFD, writeDX, flushFD, bubbleDX, mdDone, state, stallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, mult/div freeze.
// Define HAZARD_STATS_EN to enable the saturating stall-cycle counter on stallCount.
module hazard_controller #(
    parameter int unsigned MD_LATENCY = 4
) (
    input logic                clk,
    input logic                rst_n,
    hazard_controller_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_BUSY = 2'b01
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use;
    logic       pc_write, write_fd, write_dx, flush_fd, bubble_dx, md_done;

    assign load_use = bus.memRead_DX && (bus.rt_DX != 5'd0) &&
                      ((bus.rt_DX == bus.rs_FD) || (bus.rt_DX == bus.rt_FD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_write  = 1'b1;
        write_fd  = 1'b1;
        write_dx  = 1'b1;
        flush_fd  = 1'b0;
        bubble_dx = 1'b0;
        md_done   = 1'b0;
        case (state_q)
            RUN: begin
                // Priority: a taken branch squashes whatever sits behind it.
                if (bus.branchTaken_DX) begin
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (bus.mdStart_DX) begin
                    pc_write = 1'b0;
                    write_fd = 1'b0;
                    write_dx = 1'b0;
                    cnt_d    = 8'(MD_LATENCY - 1);
                    state_d  = MD_BUSY;
                end else if (load_use) begin
                    pc_write  = 1'b0;
                    write_fd  = 1'b0;
                    bubble_dx = 1'b1;
                end
            end
            MD_BUSY: begin
                pc_write = 1'b0;
                write_fd = 1'b0;
                write_dx = 1'b0;
                if (cnt_q == 8'd0) begin
                    md_done = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.pcWrite  = pc_write;
    assign bus.writeFD  = write_fd;
    assign bus.writeDX  = write_dx;
    assign bus.flushFD  = flush_fd;
    assign bus.bubbleDX = bubble_dx;
    assign bus.mdDone   = md_done;
    assign bus.state    = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stallCount = stall_cnt_q;
`else
    assign bus.stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a scoreboard queue; a second instance
// with MD_LATENCY=1 shares the stimulus to cover the shortest mult/div.
module tb_hazard_controller;
  // Output vector: {pcWrite, writeFD, writeDX, flushFD, bubbleDX, mdDone, state[1:0]}
  localparam logic [7:0] V_NORMAL = 8'b11100_0_00;
  localparam logic [7:0] V_LOAD   = 8'b00101_0_00;
  localparam logic [7:0] V_BRANCH = 8'b11111_0_00;
  localparam logic [7:0] V_ISSUE  = 8'b00000_0_00;
  localparam logic [7:0] V_BUSY   = 8'b00000_0_01;
  localparam logic [7:0] V_DONE   = 8'b00000_1_01;
  // Second instance: {mdDone, state[1:0]}
  localparam logic [2:0] S_RUN    = 3'b0_00;
  localparam logic [2:0] S_DONE   = 3'b1_01;

  logic clk;
  logic rst_n;

  logic [7:0]  exp_q[$];
  logic [2:0]  exp2_q[$];
  logic [15:0] exp_stall;
  int          total;
  int          bad;

  hazard_controller_if hif ();
  hazard_controller_if hif2 ();

  assign hif2.rs_FD          = hif.rs_FD;
  assign hif2.rt_FD          = hif.rt_FD;
  assign hif2.rt_DX          = hif.rt_DX;
  assign hif2.memRead_DX     = hif.memRead_DX;
  assign hif2.branchTaken_DX = hif.branchTaken_DX;
  assign hif2.mdStart_DX     = hif.mdStart_DX;

  hazard_controller #(.MD_LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  hazard_controller #(.MD_LATENCY(1)) dut_lat1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs_vec();
    return {hif.pcWrite, hif.writeFD, hif.writeDX, hif.flushFD, hif.bubbleDX,
            hif.mdDone, hif.state};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] stall_expect();
`ifdef HAZARD_STATS_EN
    return exp_stall;
`else
    return 16'h0000;
`endif
  endfunction

  // driver: apply one cycle of inputs, score outputs before the next rising edge
  task automatic step(input string tag, input logic br, input logic md, input logic mr,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rtdx,
                      input logic [7:0] e1, input logic [2:0] e2);
    logic [7:0] x1;
    logic [2:0] x2;
    @(negedge clk);
    hif.branchTaken_DX = br;
    hif.mdStart_DX     = md;
    hif.memRead_DX     = mr;
    hif.rs_FD          = rs;
    hif.rt_FD          = rt;
    hif.rt_DX          = rtdx;
    exp_q.push_back(e1);
    exp2_q.push_back(e2);
    #1;
    x1 = exp_q.pop_front();
    x2 = exp2_q.pop_front();
    check8({tag, "_out"}, obs_vec(), x1);
    check8({tag, "_lat1"}, {5'b0, hif2.mdDone, hif2.state}, {5'b0, x2});
    check16({tag, "_stall"}, hif.stallCount, stall_expect());
    if (!x1[7] && exp_stall != 16'hFFFF) exp_stall++;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_stall = 16'd0;
    hif.branchTaken_DX = 1'b0;
    hif.mdStart_DX     = 1'b0;
    hif.memRead_DX     = 1'b0;
    hif.rs_FD          = 5'd0;
    hif.rt_FD          = 5'd0;
    hif.rt_DX          = 5'd0;
    rst_n = 1'b0;
    #13;
    check8("reset_out", obs_vec(), V_NORMAL);
    check16("reset_stall", hif.stallCount, 16'h0000);
    // combinational rules still apply in reset
    hif.memRead_DX = 1'b1; hif.rt_DX = 5'd4; hif.rs_FD = 5'd4;
    #1;
    check8("reset_loaduse", obs_vec(), V_LOAD);
    hif.memRead_DX = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step("idle",      0, 0, 0, 5'd0, 5'd0, 5'd0, V_NORMAL, S_RUN);
    step("lu_rs",     0, 0, 1, 5'd5, 5'd0, 5'd5, V_LOAD,   S_RUN);
    step("lu_clear",  0, 0, 0, 5'd5, 5'd0, 5'd5, V_NORMAL, S_RUN);
    step("lu_rt",     0, 0, 1, 5'd3, 5'd7, 5'd7, V_LOAD,   S_RUN);
    step("lu_r0",     0, 0, 1, 5'd0, 5'd0, 5'd0, V_NORMAL, S_RUN);
    step("lu_nomatch",0, 0, 1, 5'd1, 5'd2, 5'd9, V_NORMAL, S_RUN);
    step("br_lu",     1, 0, 1, 5'd5, 5'd0, 5'd5, V_BRANCH, S_RUN);
    step("br_md",     1, 1, 0, 5'd0, 5'd0, 5'd0, V_BRANCH, S_RUN);
    step("md_issue",  0, 1, 0, 5'd0, 5'd0, 5'd0, V_ISSUE,  S_RUN);
    // inputs during the freeze must be ignored
    step("md_busy3",  1, 0, 1, 5'd5, 5'd0, 5'd5, V_BUSY,   S_DONE);
    step("md_busy2",  0, 0, 1, 5'd5, 5'd0, 5'd5, V_BUSY,   S_RUN);
    step("md_busy1",  0, 0, 0, 5'd0, 5'd0, 5'd0, V_BUSY,   S_RUN);
    step("md_done",   0, 0, 0, 5'd0, 5'd0, 5'd0, V_DONE,   S_RUN);
    step("md_rearm",  0, 1, 0, 5'd0, 5'd0, 5'd0, V_ISSUE,  S_RUN);
    step("md2_busy3", 0, 0, 0, 5'd0, 5'd0, 5'd0, V_BUSY,   S_DONE);
    step("md2_busy2", 0, 0, 0, 5'd0, 5'd0, 5'd0, V_BUSY,   S_RUN);

    // abort mid-freeze with an asynchronous reset
    #2;
    rst_n = 1'b0;
    exp_stall = 16'd0;
    #1;
    check8("abort_out", obs_vec(), V_NORMAL);
    check16("abort_stall", hif.stallCount, 16'h0000);
    @(posedge clk);
    #1;
    check8("abort_hold", obs_vec(), V_NORMAL);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_abort", 0, 0, 0, 5'd0, 5'd0, 5'd0, V_NORMAL, S_RUN);
    step("post_lu",    0, 0, 1, 5'd0, 5'd6, 5'd6, V_LOAD,   S_RUN);
    step("post_idle",  0, 0, 0, 5'd0, 5'd0, 5'd0, V_NORMAL, S_RUN);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
